// File: rtl/fht_ram_reader.sv
// FHT result RAM read-out engine: streams N points from a fixed-latency RAM over valid/ready.
// Optional macro FHT_RD_BITREV_EN selects bit-reversed read addressing.
module fht_ram_reader #(
    parameter int N       = 256,
    parameter int DATA_W  = 16,
    parameter int RAM_LAT = 2,
    localparam int ADDR_W = $clog2(N)
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iSTART,
    output logic              oBUSY,
    output logic              oRAM_RD,
    output logic [ADDR_W-1:0] oRAM_ADDR,
    input  logic [DATA_W-1:0] iRAM_DATA,
    output logic [DATA_W-1:0] oDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic              oLAST,
    output logic              oDONE
);

    localparam int FIFO_DEPTH = RAM_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int OCC_W      = $clog2(2 * RAM_LAT + 4);

    localparam logic [ADDR_W:0]  CNT_LAST  = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W:0]  CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_DEPTH = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [RAM_LAT-1:0]  vld_sr_q, vld_sr_d;

    logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]    fifo_cnt_q;

    logic                push_s, pop_s, fifo_valid_s, credit_ok_s;
    logic [OCC_W-1:0]    occ_s;

    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] k);
        logic [ADDR_W-1:0] r;
`ifdef FHT_RD_BITREV_EN
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = k[ADDR_W-1-i];
        end
`else
        r = k;
`endif
        return r;
    endfunction

    function automatic logic [OCC_W-1:0] popcnt(input logic [RAM_LAT-1:0] v);
        logic [OCC_W-1:0] c;
        c = '0;
        for (int i = 0; i < RAM_LAT; i++) begin
            if (v[i]) begin
                c = c + OCC_ONE;
            end else begin
                c = c;
            end
        end
        return c;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    assign fifo_valid_s = (fifo_cnt_q != '0);
    assign push_s       = vld_sr_q[RAM_LAT-1];
    assign pop_s        = fifo_valid_s && iREADY;

    // Everything already committed (strobe, in-flight, buffered) minus this cycle's pop must leave room.
    assign occ_s       = popcnt(vld_sr_q) + OCC_W'(rd_q) + fifo_cnt_q - OCC_W'(pop_s);
    assign credit_ok_s = (occ_s < OCC_DEPTH);

    // Next-state, read issue and counter logic.
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        if (pop_s) begin
            wr_cnt_d = wr_cnt_q + CNT_ONE;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
        vld_sr_d[0] = rd_q;
        for (int i = 1; i < RAM_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    state_d  = S_READ;
                    rd_d     = 1'b1;
                    addr_d   = map_addr('0);
                    rd_cnt_d = CNT_ONE;
                    wr_cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                if (credit_ok_s) begin
                    rd_d     = 1'b1;
                    addr_d   = map_addr(rd_cnt_q[ADDR_W-1:0]);
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                    if (rd_cnt_q == CNT_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    state_d = S_READ;
                end
            end
            S_DRAIN: begin
                if (pop_s && (wr_cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            vld_sr_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            vld_sr_q <= vld_sr_d;
        end
    end

    // Show-ahead FIFO; credit accounting guarantees a push never meets a full FIFO without a pop.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_s) begin
                fifo_mem_q[wr_ptr_q] <= iRAM_DATA;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + OCC_W'(push_s) - OCC_W'(pop_s);
        end
    end

    assign oBUSY     = (state_q != S_IDLE);
    assign oDONE     = (state_q == S_DONE);
    assign oRAM_RD   = rd_q;
    assign oRAM_ADDR = addr_q;
    assign oVALID    = fifo_valid_s;
    assign oDATA     = fifo_valid_s ? fifo_mem_q[rd_ptr_q] : '0;
    assign oLAST     = fifo_valid_s && (wr_cnt_q == CNT_LAST);

endmodule

// File: tb/tb_fht_ram_reader.sv
// Self-checking bench for fht_ram_reader (N=16, RAM_LAT=2) with a RAM model and scoreboard queues.
module tb_fht_ram_reader;

    localparam int N   = 16;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int AW  = 4;
    localparam int FD  = LAT + 2;

    logic          iCLK = 1'b0;
    logic          iRESET, iSTART, iREADY;
    logic          oBUSY, oRAM_RD, oVALID, oLAST, oDONE;
    logic [AW-1:0] oRAM_ADDR;
    logic [DW-1:0] iRAM_DATA, oDATA;

    fht_ram_reader #(.N(N), .DATA_W(DW), .RAM_LAT(LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .oBUSY(oBUSY),
        .oRAM_RD(oRAM_RD), .oRAM_ADDR(oRAM_ADDR), .iRAM_DATA(iRAM_DATA),
        .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    // RAM model with LAT-cycle read latency; junk on cycles without a read.
    logic [DW-1:0] ram  [N];
    logic [DW-1:0] pipe [LAT];
    always @(posedge iCLK) begin
        pipe[0] <= oRAM_RD ? ram[oRAM_ADDR] : 16'hDEAD;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign iRAM_DATA = pipe[LAT-1];

    typedef struct {
        int mode;       // 0 ready high, 1 stalled then high, 2 random
        int base;
        bit spam;       // extra iSTART pulses while busy
        bit pre_reset;  // abort a frame with reset before this one
        int exp_first;  // -1 means not checked
        int exp_done;
    } vec_t;
    vec_t vec [5];

    int errors = 0, checks = 0, cyc = 0;
    int exp_addr [$];
    int exp_data [$];
    bit in_frame = 1'b0, hold_pend = 1'b0, prev_last;
    int prev_data;
    int start_cyc, first_rel, done_rel, beats, lasts, dones, reads, outstanding, max_out;

    function automatic int f(input int k);
        int r;
`ifdef FHT_RD_BITREV_EN
        r = 0;
        for (int i = 0; i < AW; i++) if (k[i]) r = r | (1 << (AW - 1 - i));
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        int v;
        if (oRAM_RD) begin
            reads++;
            outstanding++;
            if (exp_addr.size() == 0) chk("extra_read", 1, 0);
            else begin
                v = exp_addr.pop_front();
                chk("rd_addr", int'(oRAM_ADDR), v);
            end
        end
        if (hold_pend) begin
            chk("hold_valid", int'(oVALID), 1);
            chk("hold_data", int'(oDATA), prev_data);
            chk("hold_last", int'(oLAST), int'(prev_last));
        end
        hold_pend = oVALID && !iREADY;
        prev_data = int'(oDATA);
        prev_last = oLAST;
        chk("last_qualified", int'(oLAST & ~oVALID), 0);
        if (in_frame && oVALID && first_rel < 0) first_rel = cyc - start_cyc;
        if (oVALID && iREADY) begin
            beats++;
            outstanding--;
            if (oLAST) lasts++;
            if (exp_data.size() == 0) chk("extra_beat", 1, 0);
            else begin
                v = exp_data.pop_front();
                chk("beat_data", int'(oDATA), v);
                chk("beat_last", int'(oLAST), int'(exp_data.size() == 0));
            end
        end
        if (outstanding > max_out) max_out = outstanding;
        if (!in_frame) begin
            chk("idle_busy", int'(oBUSY), 0);
            chk("idle_rd", int'(oRAM_RD), 0);
            chk("idle_valid", int'(oVALID), 0);
        end
        if (oDONE) begin
            dones++;
            done_rel = cyc - start_cyc;
            chk("done_after_all", exp_data.size(), 0);
            in_frame = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
        monitor();
        @(posedge iCLK);
        #1;
        cyc++;
    endtask

    task automatic setup_frame(input int base);
        for (int a = 0; a < N; a++) ram[a] = DW'(base + a);
        exp_addr.delete();
        exp_data.delete();
        for (int k = 0; k < N; k++) begin
            exp_addr.push_back(f(k));
            exp_data.push_back(base + f(k));
        end
        first_rel = -1; done_rel = -1; beats = 0; lasts = 0; dones = 0;
        reads = 0; outstanding = 0; max_out = 0;
        start_cyc = cyc;
        in_frame = 1'b1;
    endtask

    task automatic run_frame(input vec_t t);
        int rel, budget;
        setup_frame(t.base);
        iSTART = 1'b1;
        iREADY = (t.mode == 1) ? 1'b0 : 1'b1;
        tick();
        iSTART = 1'b0;
        budget = 2000;
        while (dones == 0 && budget > 0) begin
            rel = cyc - start_cyc;
            case (t.mode)
                0:       iREADY = 1'b1;
                1:       iREADY = (rel > 20);
                default: iREADY = 1'($urandom_range(0, 1));
            endcase
            iSTART = t.spam && (rel == 6 || rel == t.exp_done);
            tick();
            budget--;
        end
        iSTART = 1'b0;
        if (budget == 0) chk("frame_timeout", 1, 0);
        chk("beats", beats, N);
        chk("lasts", lasts, 1);
        chk("dones", dones, 1);
        chk("reads", reads, N);
        chk("max_buffered_le_depth", int'(max_out <= FD), 1);
        if (t.exp_first >= 0) chk("first_valid_cycle", first_rel, t.exp_first);
        if (t.exp_done >= 0) chk("done_cycle", done_rel, t.exp_done);
        for (int i = 0; i < 4; i++) begin
            iREADY = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    // Start a frame, reset after the fifth beat, then confirm a quiet restart.
    task automatic abort_frame();
        int budget;
        setup_frame(700);
        iSTART = 1'b1;
        iREADY = 1'b1;
        tick();
        iSTART = 1'b0;
        budget = 200;
        while (beats < 5 && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("abort_timeout", 1, 0);
        in_frame = 1'b0;
        hold_pend = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        iRESET = 1'b0;
        @(negedge iCLK);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_rd", int'(oRAM_RD), 0);
        chk("rst_addr", int'(oRAM_ADDR), 0);
        chk("rst_data", int'(oDATA), 0);
        chk("rst_valid", int'(oVALID), 0);
        chk("rst_last", int'(oLAST), 0);
        chk("rst_done", int'(oDONE), 0);
        @(posedge iCLK);
        #1;
        cyc++;
        iRESET = 1'b1;
        for (int i = 0; i < 8; i++) tick();
    endtask

    initial begin
        vec[0] = '{mode: 0, base: 100,  spam: 1'b0, pre_reset: 1'b0, exp_first: 4, exp_done: 20};
        vec[1] = '{mode: 1, base: 500,  spam: 1'b0, pre_reset: 1'b0, exp_first: 4, exp_done: 37};
        vec[2] = '{mode: 2, base: 900,  spam: 1'b0, pre_reset: 1'b0, exp_first: -1, exp_done: -1};
        vec[3] = '{mode: 0, base: 300,  spam: 1'b1, pre_reset: 1'b0, exp_first: 4, exp_done: 20};
        vec[4] = '{mode: 0, base: 1200, spam: 1'b0, pre_reset: 1'b1, exp_first: 4, exp_done: 20};

        iRESET = 1'b0;
        iSTART = 1'b0;
        iREADY = 1'b0;
        for (int a = 0; a < N; a++) ram[a] = '0;
        @(negedge iCLK);
        @(negedge iCLK);
        chk("reset_busy", int'(oBUSY), 0);
        chk("reset_rd", int'(oRAM_RD), 0);
        chk("reset_addr", int'(oRAM_ADDR), 0);
        chk("reset_data", int'(oDATA), 0);
        chk("reset_valid", int'(oVALID), 0);
        chk("reset_last", int'(oLAST), 0);
        chk("reset_done", int'(oDONE), 0);
        @(posedge iCLK);
        #1;
        iRESET = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        for (int i = 0; i < 5; i++) begin
            if (vec[i].pre_reset) abort_frame();
            run_frame(vec[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fht_ram_reader.md
# fht_ram_reader

Read-out engine at the output end of the FHT core. When the transform finishes writing its result RAM, this block reads all N points back through the RAM's fixed-latency read port and streams them out over a valid/ready interface. Full-rate output under continuous ready, no data loss under backpressure. Optional bit-reverse reordering at the address generator.

## Interface
Parameters:
- N, 256: transform length in points; power of two, 8..4096.
- DATA_W, 16: width of one RAM word / output sample.
- RAM_LAT, 2: RAM read latency in cycles from oRAM_RD to iRAM_DATA valid; 1..4.
- ADDR_W, $clog2(N): RAM address width (derived, not overridden).

Ports:
- iCLK, in, 1: single clock, all logic rising-edge.
- iRESET, in, 1: asynchronous, active-low reset.
- iSTART, in, 1: one-cycle pulse, result RAM ready for read-out.
- oBUSY, out, 1: high from accepted start until oDONE.
- oRAM_RD, out, 1: read strobe to result RAM.
- oRAM_ADDR, out, ADDR_W: read address.
- iRAM_DATA, in, DATA_W: read data, valid exactly RAM_LAT cycles after oRAM_RD.
- oDATA, out, DATA_W: output sample.
- oVALID, out, 1: oDATA valid.
- iREADY, in, 1: downstream accepts; a beat transfers when oVALID && iREADY.
- oLAST, out, 1: marks beat N-1; qualified by oVALID.
- oDONE, out, 1: one-cycle pulse after last beat transfers.

## Operation
- FSM states IDLE, READ, DRAIN, DONE.
- IDLE: outputs quiet; iSTART -> READ, read counter cleared, oBUSY set. iSTART outside IDLE ignored.
- READ: issue oRAM_RD with oRAM_ADDR = f(rd_cnt) whenever credit available; rd_cnt++ per issued read. After read N-1 is issued -> DRAIN.
- Credit rule: read issued only if in_flight + fifo_count < FIFO_DEPTH, FIFO_DEPTH = RAM_LAT + 2. Evaluated with the same-cycle pop counted as free. No read data is ever dropped.
- In-flight tracking: RAM_LAT-stage valid shift register on oRAM_RD; its tail pushes iRAM_DATA into the show-ahead FIFO.
- Output: oVALID = FIFO not empty; oDATA = FIFO head; pop on oVALID && iREADY. Output beat counter wr_cnt tracks transfers; oLAST = oVALID && (wr_cnt == N-1).
- DRAIN: no reads; wait until beat N-1 transfers -> DONE.
- DONE: oDONE = 1 for one cycle, oBUSY cleared, -> IDLE.
- Counters are ADDR_W+1 bits; no wrap within one frame.
- Reset (any time, including mid-frame): FSM IDLE, counters, shift register and FIFO cleared; in-flight RAM data returning after reset is discarded.
- Reset values: oBUSY 0, oRAM_RD 0, oRAM_ADDR 0, oDATA 0, oVALID 0, oLAST 0, oDONE 0.

## Timing
- iSTART sampled at cycle 0; first oRAM_RD at cycle 1 (address f(0)).
- First oVALID at cycle 2 + RAM_LAT (data registered into FIFO, presented next cycle).
- iREADY held high: one beat per cycle, N beats on cycles 2+RAM_LAT .. 1+RAM_LAT+N; oDONE at cycle 2+RAM_LAT+N.
- iREADY low: oDATA/oVALID/oLAST held stable; reads stall once credits exhausted, at most FIFO_DEPTH words buffered.
- iREADY rising after stall: transfer the same cycle if oVALID high; reads resume next cycle.
- Simultaneous push and pop on a full FIFO is legal; count unchanged.
- oDONE and a new iSTART in the same cycle: iSTART ignored (FSM not in IDLE).

## Configuration
- FHT_RD_BITREV_EN defined: f(k) = bit-reverse of k over ADDR_W bits; output emerges in natural frequency order from the core's bit-reversed RAM.
- Not defined: f(k) = k, RAM contents streamed in storage order.
- Only the address mapping changes; timing and handshake identical.

## Test plan
- N=8, RAM_LAT=2, RAM[k]=k+100, iREADY=1, macro off -> oDATA 100..107 on cycles 4..11, oLAST with 107, oDONE at cycle 12, oBUSY low from 13.
- Same setup, FHT_RD_BITREV_EN defined -> oDATA 100,104,102,106,101,105,103,107; oRAM_ADDR sequence 0,4,2,6,1,5,3,7.
- N=16, iREADY=0 for 20 cycles after iSTART then 1 -> at most 4 reads issued before stall, no beats lost, 16 beats in order, stable oDATA while stalled.
- iREADY random 50% duty, N=256, RAM_LAT=4 -> all 256 words in order, exactly one oLAST, FIFO count never exceeds 6.
- iRESET low for one cycle at beat 5 of 16 -> all outputs 0 next cycle, late RAM data discarded; fresh iSTART yields full 16-beat frame from word 0.
- iSTART pulsed while oBUSY -> ignored; single oDONE per frame.
